// File: rtl/fft_pkg.sv
// Shared types and width helpers for the radix-2 SDF FFT stage controller.
package fft_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } state_e;

  function automatic int idx_width(input int n);
    return $clog2(n);
  endfunction

  function automatic int tw_width(input int n);
    return $clog2(n) - 32'sd1;
  endfunction

  function automatic int tw_stride(input int n, input int nd);
    return n / (nd * 32'sd2);
  endfunction

endpackage

// File: rtl/ctrl_valid_pipe.sv
// LAT-deep register chain carrying the {valid, sof} output flags alongside
// the butterfly register pipeline; LAT=0 is a straight wire.
module ctrl_valid_pipe #(
  parameter int LAT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic d_valid,
  input  logic d_sof,
  output logic q_valid,
  output logic q_sof
);

  generate
    if (LAT == 0) begin : g_comb
      assign q_valid = d_valid;
      assign q_sof   = d_sof;
    end else begin : g_reg
      logic [1:0] pipe_r [LAT];

      // shift the flag pair one stage per clock, dropped on reset
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < LAT; i++) begin
            pipe_r[i] <= 2'b00;
          end
        end else begin
          pipe_r[0] <= {d_valid, d_sof};
          for (int i = 1; i < LAT; i++) begin
            pipe_r[i] <= pipe_r[i-1];
          end
        end
      end

      assign q_valid = pipe_r[LAT-1][1];
      assign q_sof   = pipe_r[LAT-1][0];
    end
  endgenerate

endmodule

// File: rtl/fft_sdf_stage_ctrl.sv
// Sequencing controller for one radix-2 SDF FFT stage: delay-line shift,
// butterfly select, twiddle address, output framing and end-of-stream drain.
module fft_sdf_stage_ctrl
  import fft_pkg::*;
#(
  parameter int N   = 128,
  parameter int ND  = 64,
  parameter int LAT = 1,
  parameter int AW  = tw_width(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic          in_sof,
  input  logic          in_last,
  output logic          in_ready,
  output logic          dl_shift,
  output logic          zero_in,
  output logic          bf_sel,
  output logic [AW-1:0] tw_addr,
  output logic          out_valid,
  output logic          out_sof,
  output logic          busy,
  output logic          err_sof
);

  localparam int     IDXW       = idx_width(N);
  localparam int     DCW        = $clog2(ND + 32'sd1);
  localparam int     STRIDE     = tw_stride(N, ND);
  // with a one-deep delay line the sof sample alone fills it
  localparam state_e SOF_STATE  = (ND == 32'sd1) ? RUN : FILL;
  localparam logic   SOF_PRIMED = (ND == 32'sd1);

  state_e            state_r, state_n;
  logic [IDXW-1:0]   idx_r, idx_n, idx_inc_s, phase_s;
  logic [DCW-1:0]    dc_r, dc_n;
  logic              primed_r, primed_n;
  logic              err_sof_r, err_sof_s;
  logic              acc_s, drain_s, misalign_s, going_run_s, last_go_s;
  logic              v0_s, sof0_s;

  assign drain_s    = (state_r == DRAIN);
  assign in_ready   = ~drain_s;
  assign acc_s      = in_valid & in_ready;
  assign dl_shift   = acc_s | drain_s;
  assign zero_in    = drain_s;
  assign busy       = (state_r != IDLE);
  assign err_sof    = err_sof_r;
  assign idx_inc_s  = idx_r + IDXW'(1'b1);
  assign misalign_s = acc_s & in_sof & (idx_r != {IDXW{1'b0}});

  assign phase_s = idx_r & IDXW'(ND * 32'sd2 - 32'sd1);
  assign bf_sel  = (phase_s >= IDXW'(ND));
  assign tw_addr = AW'(idx_r & IDXW'(ND - 32'sd1)) * AW'(STRIDE);

  // next state, sample index, drain count and priming
  always_comb begin
    state_n     = state_r;
    idx_n       = idx_r;
    dc_n        = dc_r;
    primed_n    = primed_r;
    err_sof_s   = 1'b0;
    going_run_s = 1'b0;
    last_go_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (acc_s && in_sof) begin
          state_n  = SOF_STATE;
          idx_n    = IDXW'(1'b1);
          primed_n = SOF_PRIMED;
        end else begin
          err_sof_s = acc_s;
        end
      end
      FILL, RUN: begin
        if (misalign_s) begin
          err_sof_s = 1'b1;
          state_n   = SOF_STATE;
          idx_n     = IDXW'(1'b1);
          primed_n  = SOF_PRIMED;
        end else if (acc_s) begin
          idx_n = idx_inc_s;
          if ((state_r == FILL) && (idx_r == IDXW'(ND - 32'sd1))) begin
            state_n  = RUN;
            primed_n = 1'b1;
          end else begin
            state_n = state_r;
          end
        end else begin
          idx_n = idx_r;
        end
      end
      DRAIN: begin
        idx_n = idx_inc_s;
        dc_n  = dc_r - DCW'(1'b1);
        if (dc_r == DCW'(1'b1)) begin
          state_n  = IDLE;
          primed_n = 1'b0;
          idx_n    = {IDXW{1'b0}};
        end else begin
          state_n = DRAIN;
        end
      end
      default: begin
        state_n  = IDLE;
        idx_n    = {IDXW{1'b0}};
        dc_n     = {DCW{1'b0}};
        primed_n = 1'b0;
      end
    endcase
    going_run_s = (state_r != RUN) && (state_n == RUN);
    // in_last only ends the stream once the sof rules have left us in RUN
    last_go_s   = acc_s && in_last && (state_n == RUN);
    state_n     = last_go_s ? DRAIN : state_n;
    dc_n        = last_go_s ? DCW'(ND) : dc_n;
  end

  // controller state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      idx_r     <= {IDXW{1'b0}};
      dc_r      <= {DCW{1'b0}};
      primed_r  <= 1'b0;
      err_sof_r <= 1'b0;
    end else begin
      state_r   <= state_n;
      idx_r     <= idx_n;
      dc_r      <= dc_n;
      primed_r  <= primed_n;
      err_sof_r <= err_sof_s;
    end
  end

  assign v0_s   = dl_shift & primed_r &
                  ((state_r == RUN) | (state_r == DRAIN) | going_run_s);
  assign sof0_s = v0_s & (idx_r == IDXW'(ND));

  ctrl_valid_pipe #(.LAT(LAT)) u_valid_pipe (
    .clk     (clk),
    .rst     (rst),
    .d_valid (v0_s),
    .d_sof   (sof0_s),
    .q_valid (out_valid),
    .q_sof   (out_sof)
  );

endmodule

// File: tb/tb_fft_sdf_stage_ctrl.sv
// Self-checking bench: two controller configurations driven with directed and
// random streams, compared every cycle against a sample-counting reference model.
module tb_fft_sdf_stage_ctrl;

  localparam int NA = 8,   NDA = 4, LA = 1;
  localparam int NB = 128, NDB = 1, LB = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] in_valid, in_sof, in_last;
  wire  [1:0] in_ready, dl_shift, zero_in, bf_sel, out_valid, out_sof, busy, err_sof;
  wire  [1:0] tw_a;
  wire  [5:0] tw_b;

  int n_tests = 0;
  int n_fail  = 0;

  int pn   [2] = '{NA, NB};
  int pnd  [2] = '{NDA, NDB};
  int plat [2] = '{LA, LB};

  // reference model: frame position, samples since sync, drain cycles left
  int pos [2];
  int cnt [2];
  int drn [2];
  bit infr [2];
  bit err_q [2];
  bit acc_q [2];
  bit v0_q [2];
  bit s0_q [2];
  bit vh [2][4];
  bit sh [2][4];

  bit rv, rs, rl;

  always #5 clk = ~clk;

  fft_sdf_stage_ctrl #(.N(NA), .ND(NDA), .LAT(LA)) u_dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_sof(in_sof[0]), .in_last(in_last[0]),
    .in_ready(in_ready[0]), .dl_shift(dl_shift[0]), .zero_in(zero_in[0]), .bf_sel(bf_sel[0]),
    .tw_addr(tw_a), .out_valid(out_valid[0]), .out_sof(out_sof[0]), .busy(busy[0]),
    .err_sof(err_sof[0])
  );

  fft_sdf_stage_ctrl #(.N(NB), .ND(NDB), .LAT(LB)) u_dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_sof(in_sof[1]), .in_last(in_last[1]),
    .in_ready(in_ready[1]), .dl_shift(dl_shift[1]), .zero_in(zero_in[1]), .bf_sel(bf_sel[1]),
    .tw_addr(tw_b), .out_valid(out_valid[1]), .out_sof(out_sof[1]), .busy(busy[1]),
    .err_sof(err_sof[1])
  );

  task automatic check_val(input string tag, input int k, input logic [31:0] obs,
                           input logic [31:0] exp_v);
    n_tests++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s[%0d] t=%0t got %0h expected %0h", tag, k, $time, obs, exp_v);
    end
  endtask

  task automatic reset_model();
    for (int k = 0; k < 2; k++) begin
      pos[k] = 0; cnt[k] = 0; drn[k] = 0;
      infr[k] = 1'b0; err_q[k] = 1'b0;
      acc_q[k] = 1'b0; v0_q[k] = 1'b0; s0_q[k] = 1'b0;
      for (int i = 0; i < 4; i++) begin
        vh[k][i] = 1'b0;
        sh[k][i] = 1'b0;
      end
    end
  endtask

  task automatic eval_inst(input int k);
    int  n, nd, lat, p, tw;
    bit  drain, acc, shift, v0, s0, ev, es;
    n     = pn[k];
    nd    = pnd[k];
    lat   = plat[k];
    drain = (drn[k] > 0);
    acc   = in_valid[k] && !drain;
    shift = acc || drain;
    p     = pos[k] % (2 * nd);
    tw    = (pos[k] % nd) * (n / (2 * nd));
    v0    = shift && (cnt[k] >= nd);
    s0    = v0 && (pos[k] == nd);
    acc_q[k] = acc;
    v0_q[k]  = v0;
    s0_q[k]  = s0;
    ev = (lat == 0) ? v0 : vh[k][lat-1];
    es = (lat == 0) ? s0 : sh[k][lat-1];
    check_val("in_ready",  k, 32'(in_ready[k]),  32'(!drain));
    check_val("busy",      k, 32'(busy[k]),      32'(infr[k] || drain));
    check_val("zero_in",   k, 32'(zero_in[k]),   32'(drain));
    check_val("dl_shift",  k, 32'(dl_shift[k]),  32'(shift));
    check_val("bf_sel",    k, 32'(bf_sel[k]),    32'(p >= nd));
    check_val("tw_addr",   k, (k == 0) ? 32'(tw_a) : 32'(tw_b), 32'(tw));
    check_val("out_valid", k, 32'(out_valid[k]), 32'(ev));
    check_val("out_sof",   k, 32'(out_sof[k]),   32'(es));
    check_val("err_sof",   k, 32'(err_sof[k]),   32'(err_q[k]));
  endtask

  task automatic upd_inst(input int k);
    int n, nd, lat;
    n   = pn[k];
    nd  = pnd[k];
    lat = plat[k];
    for (int i = lat - 1; i > 0; i--) begin
      vh[k][i] = vh[k][i-1];
      sh[k][i] = sh[k][i-1];
    end
    vh[k][0] = v0_q[k];
    sh[k][0] = s0_q[k];
    err_q[k] = 1'b0;
    if (drn[k] > 0) begin
      pos[k] = (pos[k] + 1) % n;
      drn[k] = drn[k] - 1;
      if (drn[k] == 0) begin
        pos[k] = 0;
        cnt[k] = 0;
      end
    end else if (acc_q[k]) begin
      if (in_sof[k] && (!infr[k] || pos[k] != 0)) begin
        err_q[k] = infr[k];
        infr[k]  = 1'b1;
        pos[k]   = 1;
        cnt[k]   = 1;
      end else if (infr[k]) begin
        pos[k] = (pos[k] + 1) % n;
        if (cnt[k] < nd) cnt[k] = cnt[k] + 1;
      end else begin
        err_q[k] = 1'b1;
      end
      if (in_last[k] && infr[k] && cnt[k] >= nd) begin
        drn[k]  = nd;
        infr[k] = 1'b0;
      end
    end
  endtask

  // called at a falling edge; returns at the next falling edge
  task automatic drive(input int k, input bit v, input bit s, input bit l);
    in_valid = 2'b00; in_sof = 2'b00; in_last = 2'b00;
    in_valid[k] = v; in_sof[k] = s; in_last[k] = l;
    #2;
    eval_inst(0);
    eval_inst(1);
    @(posedge clk);
    upd_inst(0);
    upd_inst(1);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 2'b00; in_sof = 2'b00; in_last = 2'b00;
    reset_model();
    repeat (2) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check_val("rst_in_ready",  k, 32'(in_ready[k]),  32'd1);
      check_val("rst_busy",      k, 32'(busy[k]),      32'd0);
      check_val("rst_out_valid", k, 32'(out_valid[k]), 32'd0);
      check_val("rst_err_sof",   k, 32'(err_sof[k]),   32'd0);
    end
    rst = 1'b0;
    repeat (2) drive(0, 1'b0, 1'b0, 1'b0);

    // basic frame, then a second frame with a stall after sample 2 and in_last on 7
    for (int i = 0; i < 8; i++) drive(0, 1'b1, i == 0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      drive(0, 1'b1, i == 0, i == 7);
      if (i == 2) repeat (3) drive(0, 1'b0, 1'b0, 1'b0);
    end
    repeat (8) drive(0, 1'b0, 1'b0, 1'b0);

    // misaligned sof at idx 5, stream ends at the following frame boundary
    for (int i = 0; i < 14; i++) drive(0, 1'b1, (i == 0) || (i == 5), i == 13);
    repeat (8) drive(0, 1'b0, 1'b0, 1'b0);

    // asynchronous reset between clock edges mid-RUN
    for (int i = 0; i < 6; i++) drive(0, 1'b1, i == 0, 1'b0);
    check_val("pre_rst_out_valid", 0, 32'(out_valid[0]), 32'd1);
    in_valid = 2'b01; in_sof = 2'b00; in_last = 2'b00;
    #2 rst = 1'b1;
    #1;
    check_val("arst_out_valid", 0, 32'(out_valid[0]), 32'd0);
    check_val("arst_in_ready",  0, 32'(in_ready[0]),  32'd1);
    check_val("arst_busy",      0, 32'(busy[0]),      32'd0);
    reset_model();
    @(negedge clk);
    rst = 1'b0;
    in_valid = 2'b00;
    for (int i = 0; i < 10; i++) drive(0, 1'b1, i == 0, i == 9);
    repeat (6) drive(0, 1'b0, 1'b0, 1'b0);

    // random stream on the N=8, ND=4, LAT=1 instance
    for (int c = 0; c < 500; c++) begin
      rv = ($urandom % 4) != 0;
      rs = ((pos[0] == 0) && (($urandom % 6) != 0)) || (($urandom % 50) == 0);
      rl = ($urandom % 25) == 0;
      drive(0, rv, rs, rl);
    end
    repeat (8) drive(0, 1'b0, 1'b0, 1'b0);

    // ND=1, N=128, LAT=3: directed start then random stream
    for (int i = 0; i < 12; i++) drive(1, 1'b1, i == 0, 1'b0);
    for (int c = 0; c < 600; c++) begin
      rv = ($urandom % 4) != 0;
      rs = ((pos[1] == 0) && (($urandom % 6) != 0)) || (($urandom % 80) == 0);
      rl = ($urandom % 60) == 0;
      drive(1, rv, rs, rl);
    end
    drive(1, 1'b1, 1'b0, 1'b1);
    repeat (8) drive(1, 1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
